mc_ctrl_fsm: RTL and testbench

- Multicycle main controller for the 32-bit MIPS-subset core, directly upstream of the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Produces the 2-bit aluop consumed by the ALU decoder, plus all datapath enables and mux selects.
- Covers the base set plus the extensions li, ble, sb and zfr; zfr is R-type and needs no special handling here.

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/mc_ctrl_outdec.sv | 71 +++++++
 rtl/mc_ctrl_fsm.sv | 88 ++++++++
 tb/tb_mc_ctrl_fsm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset main controller:
// opcodes, datapath select encodings, state encoding and the control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_MEMWRB = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQEX  = 4'd9,
    S_BLEEX  = 4'd10,
    S_ADDIEX = 4'd11,
    S_LIEX   = 4'd12,
    S_ITWB   = 4'd13,
    S_JEX    = 4'd14
  } statetype;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       blebranch;
    logic       iord;
    logic       memwrite;
    logic       bytewrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_SB, OP_BEQ,
      OP_BLE, OP_ADDI, OP_J, OP_LI: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control decode for the multicycle controller. Only DECODE looks at
// the opcode, and only to flag an unrecognised instruction.
import ctrl_pkg::*;

module mc_ctrl_outdec (
  input  statetype   i_state,
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.pcsrc   = PCSRC_ALU;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
      end
      // Branch target is computed speculatively here and parked in ALUOut.
      S_DECODE: begin
        o_ctrl.alusrcb = SRCB_IMMSH;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.illegal = ~op_known(i_op);
      end
      S_MEMADR, S_ADDIEX, S_LIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_MEMWRB: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.bytewrite = 1'b1;
      end
      S_RTEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BEQEX, S_BLEEX: begin
        o_ctrl.alusrca   = 1'b1;
        o_ctrl.alusrcb   = SRCB_REG;
        o_ctrl.aluop     = ALUOP_SUB;
        o_ctrl.pcsrc     = PCSRC_ALUOUT;
        o_ctrl.branch    = (i_state == S_BEQEX);
        o_ctrl.blebranch = (i_state == S_BLEEX);
      end
      S_ITWB: o_ctrl.regwrite = 1'b1;
      S_JEX: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: state register and next-state sequencing;
// all datapath controls come from mc_ctrl_outdec.
import ctrl_pkg::*;

module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       blebranch,
  output logic       iord,
  output logic       memwrite,
  output logic       bytewrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  statetype r_state;
  statetype w_next;
  ctrl_t    w_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_SB: w_next = S_MEMADR;
          OP_RTYPE:            w_next = S_RTEX;
          OP_BEQ:              w_next = S_BEQEX;
          OP_BLE:              w_next = S_BLEEX;
          OP_ADDI:             w_next = S_ADDIEX;
          OP_LI:               w_next = S_LIEX;
          OP_J:                w_next = S_JEX;
          default:             w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   w_next = S_MEMRD;
          OP_SW:   w_next = S_MEMWR;
          OP_SB:   w_next = S_MEMWRB;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD:          w_next = S_MEMWB;
      S_RTEX:           w_next = S_RTWB;
      S_ADDIEX, S_LIEX: w_next = S_ITWB;
      default:          w_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state (r_state),
    .i_op    (op),
    .o_ctrl  (w_ctrl)
  );

  assign pcwrite   = w_ctrl.pcwrite;
  assign branch    = w_ctrl.branch;
  assign blebranch = w_ctrl.blebranch;
  assign iord      = w_ctrl.iord;
  assign memwrite  = w_ctrl.memwrite;
  assign bytewrite = w_ctrl.bytewrite;
  assign irwrite   = w_ctrl.irwrite;
  assign regwrite  = w_ctrl.regwrite;
  assign regdst    = w_ctrl.regdst;
  assign memtoreg  = w_ctrl.memtoreg;
  assign alusrca   = w_ctrl.alusrca;
  assign alusrcb   = w_ctrl.alusrcb;
  assign pcsrc     = w_ctrl.pcsrc;
  assign aluop     = w_ctrl.aluop;
  assign illegal   = w_ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control words for every
// instruction class, then asynchronous reset in the middle of an R-type.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, branch, blebranch, iord, memwrite, bytewrite, irwrite;
  logic       regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;

  int totalChecks = 0;
  int badChecks = 0;

  typedef struct {
    logic [5:0]  op;
    logic [17:0] expWord;
    string       name;
  } vecT;

  vecT vecs[$];

  logic [17:0] eFetch, eDecode, eDecodeIll, eMemAdr, eMemRd, eMemWb, eMemWr, eMemWrb;
  logic [17:0] eRtEx, eRtWb, eBeqEx, eBleEx, eImmEx, eItWb, eJEx;

  mc_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .blebranch (blebranch),
    .iord      (iord),
    .memwrite  (memwrite),
    .bytewrite (bytewrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcwrite branch blebranch iord memwrite bytewrite irwrite
  // regwrite regdst memtoreg alusrca alusrcb pcsrc aluop illegal
  function automatic logic [17:0] ew(input logic pcw, input logic br, input logic bleb,
                                     input logic ird, input logic mw, input logic bw,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic m2r, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [1:0] aop,
                                     input logic ill);
    return {pcw, br, bleb, ird, mw, bw, irw, rw, rd, m2r, asa, asb, pcs, aop, ill};
  endfunction

  function automatic logic [17:0] actualWord();
    return {pcwrite, branch, blebranch, iord, memwrite, bytewrite, irwrite, regwrite,
            regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};
  endfunction

  task automatic pushVec(input logic [5:0] o, input logic [17:0] e, input string n);
    vecT v;
    v.op = o;
    v.expWord = e;
    v.name = n;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string n, input logic [17:0] e);
    logic [17:0] act;
    act = actualWord();
    totalChecks++;
    if (act !== e) begin
      badChecks++;
      $display("[TB] FAIL %s: got %b expected %b", n, act, e);
    end
    totalChecks++;
    if ((memwrite && bytewrite) || (regwrite && irwrite)) begin
      badChecks++;
      $display("[TB] FAIL %s.invariant: mw=%b bw=%b rw=%b irw=%b required no overlap",
               n, memwrite, bytewrite, regwrite, irwrite);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    op = v.op;
    #1;
    checkOutput(v.name, v.expWord);
    @(negedge clk);
  endtask

  initial begin
    eFetch     = ew(1,0,0,0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    eDecode    = ew(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    eDecodeIll = ew(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    eMemAdr    = ew(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    eMemRd     = ew(0,0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    eMemWb     = ew(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    eMemWr     = ew(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    eMemWrb    = ew(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    eRtEx      = ew(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
    eRtWb      = ew(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
    eBeqEx     = ew(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    eBleEx     = ew(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    eImmEx     = ew(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    eItWb      = ew(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0);
    eJEx       = ew(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);

    // Each instruction is listed cycle by cycle; the next FETCH row pins its length.
    pushVec(6'b100011, eFetch, "lw.fetch");   pushVec(6'b100011, eDecode, "lw.decode");
    pushVec(6'b100011, eMemAdr, "lw.memadr"); pushVec(6'b100011, eMemRd, "lw.memrd");
    pushVec(6'b100011, eMemWb, "lw.memwb");
    pushVec(6'b101000, eFetch, "sb.fetch");   pushVec(6'b101000, eDecode, "sb.decode");
    pushVec(6'b101000, eMemAdr, "sb.memadr"); pushVec(6'b101000, eMemWrb, "sb.memwrb");
    pushVec(6'b101011, eFetch, "sw.fetch");   pushVec(6'b101011, eDecode, "sw.decode");
    pushVec(6'b101011, eMemAdr, "sw.memadr"); pushVec(6'b101011, eMemWr, "sw.memwr");
    pushVec(6'b000000, eFetch, "rt.fetch");   pushVec(6'b000000, eDecode, "rt.decode");
    pushVec(6'b000000, eRtEx, "rt.ex");       pushVec(6'b000000, eRtWb, "rt.wb");
    pushVec(6'b001000, eFetch, "addi.fetch"); pushVec(6'b001000, eDecode, "addi.decode");
    pushVec(6'b001000, eImmEx, "addi.ex");    pushVec(6'b001000, eItWb, "addi.wb");
    pushVec(6'b010001, eFetch, "li.fetch");   pushVec(6'b010001, eDecode, "li.decode");
    pushVec(6'b010001, eImmEx, "li.ex");      pushVec(6'b010001, eItWb, "li.wb");
    pushVec(6'b000110, eFetch, "ble.fetch");  pushVec(6'b000110, eDecode, "ble.decode");
    pushVec(6'b000110, eBleEx, "ble.ex");
    pushVec(6'b000100, eFetch, "beq.fetch");  pushVec(6'b000100, eDecode, "beq.decode");
    pushVec(6'b000100, eBeqEx, "beq.ex");
    pushVec(6'b000010, eFetch, "j.fetch");    pushVec(6'b000010, eDecode, "j.decode");
    pushVec(6'b000010, eJEx, "j.ex");
    pushVec(6'b111111, eFetch, "ill.fetch");  pushVec(6'b111111, eDecodeIll, "ill.decode");
    pushVec(6'b000001, eFetch, "ill2.fetch"); pushVec(6'b000001, eDecodeIll, "ill2.decode");
    pushVec(6'b100011, eFetch, "lw2.fetch");  pushVec(6'b100011, eDecode, "lw2.decode");
    pushVec(6'b100011, eMemAdr, "lw2.memadr"); pushVec(6'b100011, eMemRd, "lw2.memrd");
    pushVec(6'b100011, eMemWb, "lw2.memwb");

    reset = 1'b0;
    op = 6'b100011;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.state", eFetch);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset pulled low between edges while in RTEX must show FETCH at once.
    applyStimulus('{6'b000000, eFetch, "ar.fetch"});
    applyStimulus('{6'b000000, eDecode, "ar.decode"});
    #1;
    checkOutput("ar.rtex", eRtEx);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar.async", eFetch);
    @(negedge clk);
    #1;
    checkOutput("ar.held", eFetch);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus('{6'b000010, eDecode, "ar.resume.decode"});
    applyStimulus('{6'b000010, eJEx, "ar.resume.jex"});
    applyStimulus('{6'b000010, eFetch, "ar.resume.fetch"});

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
